// File: rtl/ippcsge_pcstx_oset.sv
// 1000BASE-X PCS transmit ordered-set generator: GMII + autoneg xmit/config in, 9-bit {k,octet}
// code-groups out, with K28.5 always kept on an even slot.
module ippcsge_pcstx_oset #(
   parameter bit EXT_EN = 1'b1
) (
   input  logic        txclk,
   input  logic        rst_,
   input  logic [7:0]  txdi,
   input  logic        txen,
   input  logic        txer,
   input  logic [1:0]  xmit,
   input  logic [15:0] tx_cfdata,
   input  logic        rdisp,
   output logic [8:0]  txdo,
   output logic        tx_even,
   output logic        transmitting,
   output logic        tx_sop,
   output logic        tx_eop
);

   localparam logic [8:0] CodeK285 = 9'h1BC;
   localparam logic [8:0] CodeS    = 9'h1FB;
   localparam logic [8:0] CodeT    = 9'h1FD;
   localparam logic [8:0] CodeR    = 9'h1F7;
   localparam logic [8:0] CodeV    = 9'h1FE;
   localparam logic [8:0] CodeI1   = 9'h0C5;
   localparam logic [8:0] CodeI2   = 9'h050;
   localparam logic [8:0] CodeC1   = 9'h0B5;
   localparam logic [8:0] CodeC2   = 9'h042;

   typedef enum logic [3:0] {
      StIdleK, StIdleD, StCfgK, StCfgD, StCfgLo, StCfgHi,
      StSop, StPkt, StEopT, StExtR, StEpdR, StEpdR2
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  txdi_q;
   logic        txen_q, txer_q;
   logic [15:0] cfg_q, cfg_d;
   logic        cfg_c2_q, cfg_c2_d;
   logic [8:0]  txdo_q, code_d;
   logic        tx_even_q, transmitting_q, tx_sop_q, tx_eop_q;
   logic        tr_d, sop_d, eop_d;
   logic        xmit_data, xmit_cfg, slot_even;

   assign xmit_data = (xmit == 2'd2);
   assign xmit_cfg  = (xmit == 2'd1);
   // Parity of the slot currently being computed (registered on the next edge).
   assign slot_even = ~tx_even_q;

   // Frame boundaries look ahead at raw txen so /S/ and /T/ line up with the delayed octets.
   always_comb begin
      state_d  = state_q;
      code_d   = CodeK285;
      tr_d     = 1'b0;
      sop_d    = 1'b0;
      eop_d    = 1'b0;
      cfg_d    = cfg_q;
      cfg_c2_d = cfg_c2_q;
      unique case (state_q)
         StIdleK: begin
            cfg_c2_d = 1'b0;
            state_d  = StIdleD;
         end
         StIdleD: begin
            code_d   = rdisp ? CodeI1 : CodeI2;
            cfg_c2_d = 1'b0;
            if (xmit_data && (txen || txen_q)) state_d = StSop;
            else if (xmit_cfg)                 state_d = StCfgK;
            else                               state_d = StIdleK;
         end
         StCfgK: begin
            cfg_d   = tx_cfdata;
            state_d = StCfgD;
         end
         StCfgD: begin
            code_d  = cfg_c2_q ? CodeC2 : CodeC1;
            state_d = StCfgLo;
         end
         StCfgLo: begin
            code_d  = {1'b0, cfg_q[7:0]};
            state_d = StCfgHi;
         end
         StCfgHi: begin
            code_d   = {1'b0, cfg_q[15:8]};
            cfg_c2_d = ~cfg_c2_q;
            state_d  = xmit_cfg ? StCfgK : StIdleK;
         end
         StSop, StPkt: begin
            if (!xmit_data) begin
               code_d  = CodeV;
               state_d = StEpdR;
            end else begin
               if (state_q == StSop) begin
                  code_d = CodeS;
                  sop_d  = 1'b1;
               end else begin
                  code_d = txer_q ? CodeV : {1'b0, txdi_q};
               end
               tr_d    = 1'b1;
               state_d = txen ? StPkt : StEopT;
            end
         end
         StEopT: begin
            code_d  = CodeT;
            tr_d    = 1'b1;
            eop_d   = 1'b1;
            state_d = (EXT_EN && txer && !txen) ? StExtR : StEpdR;
         end
         StExtR: begin
            code_d  = CodeR;
            state_d = (txer && !txen) ? StExtR : StEpdR;
         end
         StEpdR: begin
            code_d   = CodeR;
            cfg_c2_d = 1'b0;
            if (slot_even)     state_d = StEpdR2;
            else if (xmit_cfg) state_d = StCfgK;
            else               state_d = StIdleK;
         end
         StEpdR2: begin
            code_d   = CodeR;
            cfg_c2_d = 1'b0;
            state_d  = xmit_cfg ? StCfgK : StIdleK;
         end
         default: state_d = StIdleK;
      endcase
   end

   always_ff @(posedge txclk or negedge rst_) begin
      if (!rst_) begin
         state_q        <= StIdleK;
         txdi_q         <= 8'h00;
         txen_q         <= 1'b0;
         txer_q         <= 1'b0;
         cfg_q          <= 16'h0000;
         cfg_c2_q       <= 1'b0;
         txdo_q         <= 9'h000;
         tx_even_q      <= 1'b0;
         transmitting_q <= 1'b0;
         tx_sop_q       <= 1'b0;
         tx_eop_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         txdi_q         <= txdi;
         txen_q         <= txen;
         txer_q         <= txer;
         cfg_q          <= cfg_d;
         cfg_c2_q       <= cfg_c2_d;
         txdo_q         <= code_d;
         tx_even_q      <= ~tx_even_q;
         transmitting_q <= tr_d;
         tx_sop_q       <= sop_d;
         tx_eop_q       <= eop_d;
      end
   end

   assign txdo         = txdo_q;
   assign tx_even      = tx_even_q;
   assign transmitting = transmitting_q;
   assign tx_sop       = tx_sop_q;
   assign tx_eop       = tx_eop_q;

endmodule
